change_dispenser: RTL and testbench

//   Pays out change to the customer: the output counterpart of the coin-counting front end.
//   It takes a change amount in 100-unit credits from the price comparator.
//   It drives the coin hopper's 500 and 100 eject solenoids one coin at a time, with an ack handshake.
//   It tracks hopper inventory and flags a fault when it cannot pay or the hopper stalls.

---
 rtl/change_dispenser.sv | 189 ++++++++++++++++++
 tb/tb_change_dispenser.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Pays change as 500/100 coins, one eject request at a time, each closed by a coin_ack pulse from the hopper.
// start -> SELECT next cycle -> eject or done two cycles after start; a missing ack faults after ACK_TIMEOUT cycles.
module change_dispenser #(
  parameter int AMT_W        = 4,
  parameter int INV_W        = 6,
  parameter int INV_500_INIT = 10,
  parameter int INV_100_INIT = 20,
  parameter int ACK_TIMEOUT  = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             coin_ack,
  input  logic             refill,
  output logic             eject_500,
  output logic             eject_100,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining,
  output logic [INV_W-1:0] inv_500,
  output logic [INV_W-1:0] inv_100
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [INV_W-1:0] INV_500_RST = INV_W'(INV_500_INIT);
  localparam logic [INV_W-1:0] INV_100_RST = INV_W'(INV_100_INIT);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [AMT_W-1:0] VAL_500     = AMT_W'(5);
  localparam logic [AMT_W-1:0] VAL_100     = AMT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] ack_cnt;
  logic [CNT_W-1:0] ack_cnt_nxt;

  logic             eject_500_nxt;
  logic             eject_100_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             fault_nxt;
  logic [AMT_W-1:0] remaining_nxt;
  logic [INV_W-1:0] inv_500_nxt;
  logic [INV_W-1:0] inv_100_nxt;

  logic             can_pay_500;
  logic             can_pay_100;
  logic             timeout_hit;

  // Greedy selection: a 500 coin whenever it fits and one is in stock.
  assign can_pay_500 = (remaining >= VAL_500) && (inv_500 != '0);
  assign can_pay_100 = (inv_100 != '0);
  assign timeout_hit = (ack_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ack_cnt   <= '0;
      eject_500 <= 1'b0;
      eject_100 <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      remaining <= '0;
      inv_500   <= INV_500_RST;
      inv_100   <= INV_100_RST;
    end else begin
      state     <= state_nxt;
      ack_cnt   <= ack_cnt_nxt;
      eject_500 <= eject_500_nxt;
      eject_100 <= eject_100_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      fault     <= fault_nxt;
      remaining <= remaining_nxt;
      inv_500   <= inv_500_nxt;
      inv_100   <= inv_100_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ack_cnt_nxt   = ack_cnt;
    eject_500_nxt = 1'b0;
    eject_100_nxt = 1'b0;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    fault_nxt     = 1'b0;
    remaining_nxt = remaining;
    inv_500_nxt   = inv_500;
    inv_100_nxt   = inv_100;

    case (state)
      S_IDLE: begin
        busy_nxt = 1'b0;
        if (refill) begin
          inv_500_nxt = INV_500_RST;
          inv_100_nxt = INV_100_RST;
        end
        if (start) begin
          remaining_nxt = amount;
          busy_nxt      = 1'b1;
          state_nxt     = S_SELECT;
        end
      end

      S_SELECT: begin
        busy_nxt    = 1'b1;
        ack_cnt_nxt = '0;
        if (remaining == '0) begin
          // busy falls together with the done pulse.
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else if (can_pay_500) begin
          eject_500_nxt = 1'b1;
          state_nxt     = S_EJECT;
        end else if (can_pay_100) begin
          eject_100_nxt = 1'b1;
          state_nxt     = S_EJECT;
        end else begin
          fault_nxt = 1'b1;
          state_nxt = S_FAULT;
        end
      end

      S_EJECT: begin
        eject_500_nxt = eject_500;
        eject_100_nxt = eject_100;
        if (coin_ack) begin
          // An ack arriving on the last timeout cycle still counts as paid.
          eject_500_nxt = 1'b0;
          eject_100_nxt = 1'b0;
          state_nxt     = S_SELECT;
          if (eject_500) begin
            if (remaining >= VAL_500) remaining_nxt = remaining - VAL_500;
            if (inv_500 != '0)        inv_500_nxt   = inv_500 - 1'b1;
          end else begin
            if (remaining != '0)      remaining_nxt = remaining - VAL_100;
            if (inv_100 != '0)        inv_100_nxt   = inv_100 - 1'b1;
          end
        end else if (timeout_hit) begin
          eject_500_nxt = 1'b0;
          eject_100_nxt = 1'b0;
          fault_nxt     = 1'b1;
          state_nxt     = S_FAULT;
        end else begin
          ack_cnt_nxt = ack_cnt + 1'b1;
        end
      end

      S_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      S_FAULT: begin
        busy_nxt  = 1'b1;
        fault_nxt = 1'b1;
        if (refill) begin
          inv_500_nxt = INV_500_RST;
          inv_100_nxt = INV_100_RST;
          fault_nxt   = 1'b0;
          state_nxt   = S_SELECT;
        end
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // The hopper must never see both solenoids energised.
  assert property (@(posedge clk) disable iff (!reset_n) !(eject_500 && eject_100));
  assert property (@(posedge clk) disable iff (!reset_n) !(done && busy));

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized payouts vs a greedy coin model.
module tb_change_dispenser;

  localparam int AMT_W = 4;
  localparam int INV_W = 6;
  localparam int I5    = 10;
  localparam int I1    = 20;
  localparam int TO    = 1000;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             coin_ack;
  logic             refill;
  logic             eject_500;
  logic             eject_100;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] remaining;
  logic [INV_W-1:0] inv_500;
  logic [INV_W-1:0] inv_100;

  int n_pass  = 0;
  int n_total = 0;
  int m_i5;
  int m_i1;

  change_dispenser #(
    .AMT_W(AMT_W), .INV_W(INV_W), .INV_500_INIT(I5), .INV_100_INIT(I1), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .amount(amount), .coin_ack(coin_ack),
    .refill(refill), .eject_500(eject_500), .eject_100(eject_100), .busy(busy), .done(done),
    .fault(fault), .remaining(remaining), .inv_500(inv_500), .inv_100(inv_100)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_activity(input int limit);
    int k = 0;
    while (!(eject_500 || eject_100 || done || fault) && k < limit) begin
      tick();
      k++;
    end
  endtask

  task automatic pulse_ack();
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; amount = '0; coin_ack = 1'b0; refill = 1'b0;
    repeat (3) tick();
    n_total++; if ({eject_500, eject_100} !== 2'b00) $display("FAIL reset_eject: got %b want 00", {eject_500, eject_100}); else n_pass++;
    n_total++; if ({busy, done, fault} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, fault}); else n_pass++;
    n_total++; if (remaining !== '0) $display("FAIL reset_remaining: got %0d want 0", remaining); else n_pass++;
    n_total++; if (inv_500 !== INV_W'(I5) || inv_100 !== INV_W'(I1))
      $display("FAIL reset_inv: got %0d/%0d want %0d/%0d", inv_500, inv_100, I5, I1); else n_pass++;
    reset_n = 1'b1;
    m_i5 = I5; m_i1 = I1;
    tick();
  endtask

  task automatic test_amount7();
    bit exp_500 [3] = '{1'b1, 1'b0, 1'b0};
    int rem = 7;
    amount = AMT_W'(7); start = 1'b1; tick(); start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL a7_busy: got %b want 1", busy); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      wait_activity(20);
      n_total++; if ({eject_500, eject_100} !== {exp_500[i], !exp_500[i]})
        $display("FAIL a7_coin%0d: got %b want %b", i, {eject_500, eject_100}, {exp_500[i], !exp_500[i]}); else n_pass++;
      tick(); tick();
      pulse_ack();
      if (exp_500[i]) begin rem -= 5; m_i5--; end else begin rem -= 1; m_i1--; end
      n_total++; if (remaining !== AMT_W'(rem) || {eject_500, eject_100} !== 2'b00)
        $display("FAIL a7_after_ack%0d: got rem %0d ej %b want %0d 00", i, remaining, {eject_500, eject_100}, rem); else n_pass++;
    end
    wait_activity(10);
    n_total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL a7_done: got done %b busy %b want 1 0", done, busy); else n_pass++;
    n_total++; if (inv_500 !== INV_W'(9) || inv_100 !== INV_W'(18) || remaining !== '0)
      $display("FAIL a7_inv: got %0d/%0d rem %0d want 9/18 rem 0", inv_500, inv_100, remaining); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL a7_done_pulse: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_zero();
    amount = '0; start = 1'b1; tick(); start = 1'b0;
    n_total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL zero_n1: got busy %b done %b want 1 0", busy, done); else n_pass++;
    tick();
    n_total++; if (done !== 1'b1 || busy !== 1'b0 || {eject_500, eject_100} !== 2'b00)
      $display("FAIL zero_n2: got done %b busy %b ej %b want 1 0 00", done, busy, {eject_500, eject_100}); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_n3: got done %b busy %b want 0 0", done, busy); else n_pass++;
  endtask

  task automatic test_start_ignored();
    amount = AMT_W'(5); start = 1'b1; tick(); start = 1'b0;
    wait_activity(10);
    n_total++; if (eject_500 !== 1'b1) $display("FAIL ign_eject: got %b want 1", eject_500); else n_pass++;
    amount = AMT_W'(3); start = 1'b1; refill = 1'b1; tick(); start = 1'b0; refill = 1'b0;
    n_total++; if (remaining !== AMT_W'(5) || eject_500 !== 1'b1)
      $display("FAIL ign_start: got rem %0d ej %b want 5 1", remaining, eject_500); else n_pass++;
    pulse_ack();
    m_i5--;
    n_total++; if (inv_500 !== INV_W'(m_i5) || remaining !== '0)
      $display("FAIL ign_refill: got inv %0d rem %0d want %0d 0", inv_500, remaining, m_i5); else n_pass++;
    wait_activity(10);
    n_total++; if (done !== 1'b1) $display("FAIL ign_done: got %b want 1", done); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    amount = AMT_W'(2); start = 1'b1; tick(); start = 1'b0;
    wait_activity(10);
    while (eject_100 && n < TO + 50) begin tick(); n++; end
    n_total++; if (n !== TO) $display("FAIL to_cycles: got %0d want %0d", n, TO); else n_pass++;
    n_total++; if (fault !== 1'b1 || busy !== 1'b1 || remaining !== AMT_W'(2) || inv_100 !== INV_W'(m_i1))
      $display("FAIL to_fault: got f %b b %b rem %0d inv %0d want 1 1 2 %0d", fault, busy, remaining, inv_100, m_i1); else n_pass++;
    pulse_ack();
    n_total++; if (fault !== 1'b1 || remaining !== AMT_W'(2) || inv_100 !== INV_W'(m_i1))
      $display("FAIL to_ack_in_fault: got f %b rem %0d inv %0d want 1 2 %0d", fault, remaining, inv_100, m_i1); else n_pass++;
    refill = 1'b1; tick(); refill = 1'b0;
    m_i5 = I5; m_i1 = I1;
    n_total++; if (fault !== 1'b0 || busy !== 1'b1 || inv_500 !== INV_W'(I5) || inv_100 !== INV_W'(I1))
      $display("FAIL to_refill: got f %b b %b inv %0d/%0d want 0 1 %0d/%0d", fault, busy, inv_500, inv_100, I5, I1); else n_pass++;
    wait_activity(10);
    repeat (TO - 1) tick();
    pulse_ack();
    m_i1--;
    n_total++; if (fault !== 1'b0 || remaining !== AMT_W'(1) || inv_100 !== INV_W'(m_i1))
      $display("FAIL to_last_cycle_ack: got f %b rem %0d inv %0d want 0 1 %0d", fault, remaining, inv_100, m_i1); else n_pass++;
    wait_activity(10);
    pulse_ack();
    m_i1--;
    wait_activity(10);
    n_total++; if (done !== 1'b1 || inv_100 !== INV_W'(m_i1))
      $display("FAIL to_done: got done %b inv %0d want 1 %0d", done, inv_100, m_i1); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_eject();
    amount = AMT_W'(9); start = 1'b1; tick(); start = 1'b0;
    wait_activity(10);
    pulse_ack();
    wait_activity(10);
    n_total++; if (eject_100 !== 1'b1 || inv_500 !== INV_W'(m_i5 - 1))
      $display("FAIL rst_pre: got ej100 %b inv500 %0d want 1 %0d", eject_100, inv_500, m_i5 - 1); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_total++; if ({eject_500, eject_100} !== 2'b00 || busy !== 1'b0 || remaining !== '0)
      $display("FAIL rst_async: got ej %b busy %b rem %0d want 00 0 0", {eject_500, eject_100}, busy, remaining); else n_pass++;
    n_total++; if (inv_500 !== INV_W'(I5) || inv_100 !== INV_W'(I1))
      $display("FAIL rst_inv: got %0d/%0d want %0d/%0d", inv_500, inv_100, I5, I1); else n_pass++;
    tick();
    reset_n = 1'b1;
    m_i5 = I5; m_i1 = I1;
    tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int rem;
      int guard;
      bit pay_500;
      if ($urandom_range(0, 5) == 0) begin
        refill = 1'b1; tick(); refill = 1'b0;
        m_i5 = I5; m_i1 = I1;
        n_total++; if (inv_500 !== INV_W'(m_i5) || inv_100 !== INV_W'(m_i1))
          $display("FAIL rnd_idle_refill: got %0d/%0d want %0d/%0d", inv_500, inv_100, m_i5, m_i1); else n_pass++;
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_ack();
        n_total++; if (busy !== 1'b0 || inv_500 !== INV_W'(m_i5) || inv_100 !== INV_W'(m_i1))
          $display("FAIL rnd_idle_ack: got busy %b inv %0d/%0d want 0 %0d/%0d", busy, inv_500, inv_100, m_i5, m_i1); else n_pass++;
      end
      rem = $urandom_range(0, 15);
      amount = AMT_W'(rem); start = 1'b1; tick(); start = 1'b0;
      guard = 0;
      while (rem > 0 && guard < 40) begin
        guard++;
        wait_activity(20);
        if (rem >= 5 && m_i5 > 0) pay_500 = 1'b1;
        else if (m_i1 > 0)        pay_500 = 1'b0;
        else begin
          n_total++; if (fault !== 1'b1 || remaining !== AMT_W'(rem))
            $display("FAIL rnd_fault t%0d: got f %b rem %0d want 1 %0d", t, fault, remaining, rem); else n_pass++;
          refill = 1'b1; tick(); refill = 1'b0;
          m_i5 = I5; m_i1 = I1;
          continue;
        end
        n_total++; if ({eject_500, eject_100} !== {pay_500, !pay_500})
          $display("FAIL rnd_coin t%0d: got %b want %b", t, {eject_500, eject_100}, {pay_500, !pay_500}); else n_pass++;
        repeat ($urandom_range(0, 4)) tick();
        pulse_ack();
        if (pay_500) begin rem -= 5; m_i5--; end else begin rem -= 1; m_i1--; end
        n_total++; if (remaining !== AMT_W'(rem))
          $display("FAIL rnd_rem t%0d: got %0d want %0d", t, remaining, rem); else n_pass++;
      end
      wait_activity(20);
      n_total++; if (done !== 1'b1 || remaining !== '0 || inv_500 !== INV_W'(m_i5) || inv_100 !== INV_W'(m_i1))
        $display("FAIL rnd_done t%0d: got done %b rem %0d inv %0d/%0d want 1 0 %0d/%0d",
                 t, done, remaining, inv_500, inv_100, m_i5, m_i1); else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_amount7();
    test_zero();
    test_start_ignored();
    test_timeout();
    test_reset_mid_eject();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
